// File: rtl/timer_apb_slave.sv
// rtl/timer_apb_slave.sv - APB slave front-end for the timer register file (optional macro APB_TIMER_PSLVERR_EN)
module timer_apb_slave #(
    parameter int WAIT_STATES = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        psel,
    input  logic        penable,
    input  logic        pwrite,
    input  logic [31:0] paddr,
    input  logic [31:0] pwdata,
    input  logic [3:0]  pstrb,
    output logic        pready,
    output logic [31:0] prdata,
    output logic        pslverr,
    output logic        wr_en,
    output logic        rd_en,
    output logic [31:0] addr,
    output logic [31:0] wdata,
    input  logic [31:0] tcr,
    input  logic [31:0] tdr0,
    input  logic [31:0] tdr1,
    input  logic [31:0] tcmp0,
    input  logic [31:0] tcmp1,
    input  logic [31:0] tier,
    input  logic [31:0] tisr,
    input  logic [31:0] thcsr
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_e;

    // Counter preload; only meaningful when at least one wait state is configured.
    localparam logic [3:0] CNT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic        write_q, write_d;
    logic [31:0] pwdata_q, pwdata_d;
    logic [3:0]  strb_q, strb_d;
    logic [31:0] prdata_q, prdata_d;

    logic        setup_phase;
    logic        in_done;
    logic        valid_q;
    logic [31:0] rb_cur;
    logic [31:0] rb_next;
    logic [31:0] wdata_merged;

    // Eight word-aligned registers occupy 0x00..0x1C; anything else is unmapped.
    function automatic logic addr_is_valid(input logic [31:0] a);
        return (a[31:5] == 27'd0) && (a[1:0] == 2'b00);
    endfunction

    assign setup_phase = psel & ~penable;
    assign in_done     = (state_q == DONE);
    assign valid_q     = addr_is_valid(addr_q);

    // Readback of the register addressed by the latched transfer (feeds the byte merge).
    always_comb begin
        rb_cur = '0;
        case (addr_q[4:2])
            3'd0: rb_cur = tcr;
            3'd1: rb_cur = tdr0;
            3'd2: rb_cur = tdr1;
            3'd3: rb_cur = tcmp0;
            3'd4: rb_cur = tcmp1;
            3'd5: rb_cur = tier;
            3'd6: rb_cur = tisr;
            3'd7: rb_cur = thcsr;
            default: rb_cur = '0;
        endcase
    end

    // Readback of the register addressed by the next-state address, so a zero-wait
    // read can capture data on the same edge that latches paddr.
    always_comb begin
        rb_next = '0;
        case (addr_d[4:2])
            3'd0: rb_next = tcr;
            3'd1: rb_next = tdr0;
            3'd2: rb_next = tdr1;
            3'd3: rb_next = tcmp0;
            3'd4: rb_next = tcmp1;
            3'd5: rb_next = tier;
            3'd6: rb_next = tisr;
            3'd7: rb_next = thcsr;
            default: rb_next = '0;
        endcase
    end

    // Transfer sequencing: accept setup only from IDLE, count wait states, complete in DONE.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        write_d  = write_q;
        pwdata_d = pwdata_q;
        strb_d   = strb_q;
        case (state_q)
            IDLE: begin
                if (setup_phase) begin
                    addr_d   = paddr;
                    write_d  = pwrite;
                    pwdata_d = pwdata;
                    strb_d   = pstrb;
                    if (WAIT_STATES == 0) begin
                        state_d = DONE;
                        cnt_d   = 4'd0;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_LOAD;
                    end
                end
            end
            WAIT: begin
                if (!psel) begin
                    // Master abandoned the transfer; no register strobe is issued.
                    state_d = IDLE;
                    cnt_d   = 4'd0;
                end else if (cnt_q == 4'd0) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DONE: begin
                // A setup phase seen here is deliberately not latched.
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // Read data is captured only on the edge entering DONE for a valid read; zero otherwise.
    always_comb begin
        prdata_d = '0;
        if ((state_d == DONE) && (state_q != DONE) && !write_d && addr_is_valid(addr_d)) begin
            prdata_d = rb_next;
        end
    end

    // Byte-lane merge: strobed lanes take new data, the rest keep the live register value.
    always_comb begin
        wdata_merged = rb_cur;
        for (int i = 0; i < 4; i++) begin
            if (strb_q[i]) begin
                wdata_merged[8*i +: 8] = pwdata_q[8*i +: 8];
            end
        end
    end

    // State and latched-transfer registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= 4'd0;
            addr_q   <= '0;
            write_q  <= 1'b0;
            pwdata_q <= '0;
            strb_q   <= 4'd0;
            prdata_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            write_q  <= write_d;
            pwdata_q <= pwdata_d;
            strb_q   <= strb_d;
            prdata_q <= prdata_d;
        end
    end

    assign pready = in_done;
    assign prdata = prdata_q;
    assign addr   = addr_q;
    assign wr_en  = in_done & write_q & valid_q;
    assign rd_en  = in_done & ~write_q & valid_q;
    assign wdata  = wr_en ? wdata_merged : 32'd0;

`ifdef APB_TIMER_PSLVERR_EN
    assign pslverr = in_done & ~valid_q;
`else
    assign pslverr = 1'b0;
`endif

endmodule

// File: tb/tb_timer_apb_slave.sv
// tb/tb_timer_apb_slave.sv - scoreboard bench for timer_apb_slave at WAIT_STATES 0, 2 and 3
module tb_timer_apb_slave;

    typedef struct packed {
        logic [7:0]  cycles;
        logic [7:0]  wr;
        logic [7:0]  rd;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] prdata;
        logic        slverr;
    } txn_t;

    logic        clk;
    logic        rst;
    logic        psel, penable, pwrite;
    logic [31:0] paddr, pwdata;
    logic [3:0]  pstrb;
    logic [31:0] tcr, tdr0, tdr1, tcmp0, tcmp1, tier, tisr, thcsr;

    logic [2:0]        pready_w, pslverr_w, wr_en_w, rd_en_w;
    logic [2:0][31:0]  prdata_w, addr_w, wdata_w;

    int   ws_of [3] = '{0, 2, 3};
    txn_t sb[$];
    int   tests_run;
    int   tests_failed;

    timer_apb_slave #(.WAIT_STATES(0)) u_ws0 (
        .clk(clk), .rst(rst), .psel(psel), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
        .pready(pready_w[0]), .prdata(prdata_w[0]), .pslverr(pslverr_w[0]),
        .wr_en(wr_en_w[0]), .rd_en(rd_en_w[0]), .addr(addr_w[0]), .wdata(wdata_w[0]),
        .tcr(tcr), .tdr0(tdr0), .tdr1(tdr1), .tcmp0(tcmp0), .tcmp1(tcmp1),
        .tier(tier), .tisr(tisr), .thcsr(thcsr)
    );

    timer_apb_slave #(.WAIT_STATES(2)) u_ws2 (
        .clk(clk), .rst(rst), .psel(psel), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
        .pready(pready_w[1]), .prdata(prdata_w[1]), .pslverr(pslverr_w[1]),
        .wr_en(wr_en_w[1]), .rd_en(rd_en_w[1]), .addr(addr_w[1]), .wdata(wdata_w[1]),
        .tcr(tcr), .tdr0(tdr0), .tdr1(tdr1), .tcmp0(tcmp0), .tcmp1(tcmp1),
        .tier(tier), .tisr(tisr), .thcsr(thcsr)
    );

    timer_apb_slave #(.WAIT_STATES(3)) u_ws3 (
        .clk(clk), .rst(rst), .psel(psel), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
        .pready(pready_w[2]), .prdata(prdata_w[2]), .pslverr(pslverr_w[2]),
        .wr_en(wr_en_w[2]), .rd_en(rd_en_w[2]), .addr(addr_w[2]), .wdata(wdata_w[2]),
        .tcr(tcr), .tdr0(tdr0), .tdr1(tdr1), .tcmp0(tcmp0), .tcmp1(tcmp1),
        .tier(tier), .tisr(tisr), .thcsr(thcsr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic ref_valid(input logic [31:0] a);
        for (int i = 0; i < 8; i++) begin
            if (a == 32'(i * 4)) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic logic [31:0] ref_rb(input logic [31:0] a);
        case (a)
            32'h00: return tcr;
            32'h04: return tdr0;
            32'h08: return tdr1;
            32'h0C: return tcmp0;
            32'h10: return tcmp1;
            32'h14: return tier;
            32'h18: return tisr;
            32'h1C: return thcsr;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] ref_merge(input logic [31:0] wd, input logic [3:0] s, input logic [31:0] old);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) begin
            if (s[i]) r[8*i +: 8] = wd[8*i +: 8];
        end
        return r;
    endfunction

    task automatic push_exp(input int d, input logic w, input logic [31:0] a,
                            input logic [31:0] wd, input logic [3:0] s);
        txn_t e;
        logic v;
        v = ref_valid(a);
        e = '0;
        e.cycles = 8'(ws_of[d] + 1);
        e.addr   = a;
        if (w && v) begin
            e.wr    = 8'd1;
            e.wdata = ref_merge(wd, s, ref_rb(a));
        end
        if (!w && v) begin
            e.rd     = 8'd1;
            e.prdata = ref_rb(a);
        end
`ifdef APB_TIMER_PSLVERR_EN
        e.slverr = !v;
`endif
        sb.push_back(e);
    endtask

    task automatic xfer(input int d, input logic w, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] s, input logic rel,
                        output txn_t o, output logic pre, output logic post, output logic early);
        int   n;
        logic got;
        o = '0; pre = 1'b0; post = 1'b0; early = 1'b0; got = 1'b0; n = 0;
        @(negedge clk);
        pre = pready_w[d] | wr_en_w[d] | rd_en_w[d];
        psel = 1'b1; penable = 1'b0; pwrite = w; paddr = a; pwdata = wd; pstrb = s;
        while (!got && n < 20) begin
            @(negedge clk);
            penable = 1'b1;
            n++;
            o.wr = o.wr + 8'(wr_en_w[d]);
            o.rd = o.rd + 8'(rd_en_w[d]);
            if (pready_w[d]) begin
                got      = 1'b1;
                o.cycles = 8'(n);
                o.addr   = addr_w[d];
                o.wdata  = wdata_w[d];
                o.prdata = prdata_w[d];
                o.slverr = pslverr_w[d];
            end else begin
                early = early | (prdata_w[d] != 32'd0) | pslverr_w[d];
            end
        end
        if (!got) o.cycles = 8'hFF;
        if (rel) begin
            @(negedge clk);
            post = pready_w[d] | wr_en_w[d] | rd_en_w[d];
            psel = 1'b0; penable = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h0C; pwdata = '1; pstrb = '1;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            tests_run++;
            if ({pready_w[d], prdata_w[d], pslverr_w[d], wr_en_w[d], rd_en_w[d], addr_w[d], wdata_w[d]} !== '0) begin
                tests_failed++;
                $display("FAIL reset_outputs[%0d]: got rdy=%b prdata=%h err=%b wr=%b rd=%b addr=%h wdata=%h, expected all zero",
                         d, pready_w[d], prdata_w[d], pslverr_w[d], wr_en_w[d], rd_en_w[d], addr_w[d], wdata_w[d]);
            end
        end
        rst = 1'b0; psel = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0; pstrb = '0;
    endtask

    task automatic test_write_ws0();
        txn_t e, o;
        logic pre, post, early;
        tcmp0 = 32'h5555_5555;
        push_exp(0, 1'b1, 32'h0C, 32'h0000_1234, 4'hF);
        xfer(0, 1'b1, 32'h0C, 32'h0000_1234, 4'hF, 1'b1, o, pre, post, early);
        e = sb.pop_front();
        tests_run++;
        if (o !== e) begin
            tests_failed++;
            $display("FAIL write_ws0_txn: got %h expected %h", o, e);
        end
        tests_run++;
        if (o.wdata !== 32'h0000_1234) begin
            tests_failed++;
            $display("FAIL write_ws0_wdata: got %h expected 00001234", o.wdata);
        end
        tests_run++;
        if (post !== 1'b0) begin
            tests_failed++;
            $display("FAIL write_ws0_single_pulse: got %b expected 0", post);
        end
    endtask

    task automatic test_read_ws2();
        txn_t e, o;
        logic pre, post, early;
        tcmp1 = 32'hFFFF_FFFF;
        push_exp(1, 1'b0, 32'h10, 32'd0, 4'h0);
        xfer(1, 1'b0, 32'h10, 32'd0, 4'h0, 1'b1, o, pre, post, early);
        e = sb.pop_front();
        tests_run++;
        if (o !== e) begin
            tests_failed++;
            $display("FAIL read_ws2_txn: got %h expected %h", o, e);
        end
        tests_run++;
        if ({early, post} !== 2'b00) begin
            tests_failed++;
            $display("FAIL read_ws2_outside_done: got early=%b post=%b expected 0 0", early, post);
        end
    endtask

    task automatic test_partial_write();
        txn_t e, o;
        logic pre, post, early;
        logic [31:0] rb [3];
        logic [31:0] wd [3];
        logic [3:0]  st [3];
        rb[0] = 32'hFFFF_FFFF; wd[0] = 32'h0000_00AB; st[0] = 4'b0001;
        rb[1] = 32'hCAFE_F00D; wd[1] = 32'h1234_5678; st[1] = 4'b0000;
        rb[2] = $urandom;      wd[2] = $urandom;      st[2] = 4'b1010;
        for (int k = 0; k < 3; k++) begin
            tcmp0 = rb[k];
            push_exp(1, 1'b1, 32'h0C, wd[k], st[k]);
            xfer(1, 1'b1, 32'h0C, wd[k], st[k], 1'b1, o, pre, post, early);
            e = sb.pop_front();
            tests_run++;
            if (o !== e) begin
                tests_failed++;
                $display("FAIL partial_write[%0d]: got %h expected %h", k, o, e);
            end
            if (k == 0) begin
                tests_run++;
                if (o.wdata !== 32'hFFFF_FFAB) begin
                    tests_failed++;
                    $display("FAIL partial_write_lane0: got %h expected ffffffab", o.wdata);
                end
            end
        end
    endtask

    task automatic test_read_decode();
        txn_t e, o;
        logic pre, post, early;
        tcr = $urandom; tdr0 = $urandom; tdr1 = $urandom; tcmp0 = $urandom;
        tcmp1 = $urandom; tier = $urandom; tisr = $urandom; thcsr = $urandom;
        for (int i = 0; i < 8; i++) begin
            push_exp(0, 1'b0, 32'(i * 4), 32'd0, 4'h0);
            xfer(0, 1'b0, 32'(i * 4), 32'd0, 4'h0, 1'b1, o, pre, post, early);
            e = sb.pop_front();
            tests_run++;
            if (o !== e) begin
                tests_failed++;
                $display("FAIL read_decode[%h]: got %h expected %h", i * 4, o, e);
            end
        end
    endtask

    task automatic test_invalid();
        txn_t e, o;
        logic pre, post, early;
        logic [31:0] ad [4];
        logic        wr [4];
        ad[0] = 32'h20;        wr[0] = 1'b1;
        ad[1] = 32'h0D;        wr[1] = 1'b0;
        ad[2] = 32'h06;        wr[2] = 1'b1;
        ad[3] = 32'hFFFF_FFFC; wr[3] = 1'b0;
        for (int k = 0; k < 4; k++) begin
            push_exp(0, wr[k], ad[k], 32'hA5A5_A5A5, 4'hF);
            xfer(0, wr[k], ad[k], 32'hA5A5_A5A5, 4'hF, 1'b1, o, pre, post, early);
            e = sb.pop_front();
            tests_run++;
            if (o !== e) begin
                tests_failed++;
                $display("FAIL invalid_addr[%h]: got %h expected %h", ad[k], o, e);
            end
        end
    endtask

    task automatic test_abort_reset();
        txn_t e, o;
        logic pre, post, early;
        int   wr_seen;
        wr_seen = 0;
        @(negedge clk);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h04; pwdata = 32'hDEAD_BEEF; pstrb = 4'hF;
        @(negedge clk);
        penable = 1'b1;
        wr_seen += int'(wr_en_w[2]);
        @(negedge clk);
        wr_seen += int'(wr_en_w[2]);
        rst = 1'b1;
        #1;
        tests_run++;
        if ({pready_w[2], prdata_w[2], pslverr_w[2], wr_en_w[2], rd_en_w[2], addr_w[2], wdata_w[2]} !== '0) begin
            tests_failed++;
            $display("FAIL abort_reset_outputs: got rdy=%b prdata=%h err=%b wr=%b rd=%b addr=%h wdata=%h, expected all zero",
                     pready_w[2], prdata_w[2], pslverr_w[2], wr_en_w[2], rd_en_w[2], addr_w[2], wdata_w[2]);
        end
        @(negedge clk);
        wr_seen += int'(wr_en_w[2]);
        rst = 1'b0; psel = 1'b0; penable = 1'b0;
        repeat (4) begin
            @(negedge clk);
            wr_seen += int'(wr_en_w[2]);
        end
        tests_run++;
        if (wr_seen !== 0) begin
            tests_failed++;
            $display("FAIL abort_no_write: got %0d wr_en cycles expected 0", wr_seen);
        end
        tcr = $urandom;
        push_exp(2, 1'b0, 32'h00, 32'd0, 4'h0);
        xfer(2, 1'b0, 32'h00, 32'd0, 4'h0, 1'b1, o, pre, post, early);
        e = sb.pop_front();
        tests_run++;
        if (o !== e) begin
            tests_failed++;
            $display("FAIL abort_then_read: got %h expected %h", o, e);
        end
    endtask

    task automatic test_back_to_back();
        txn_t e, o;
        logic pre, post, early;
        for (int d = 0; d < 2; d++) begin
            tdr0 = $urandom;
            push_exp(d, 1'b1, 32'h04, 32'h0BAD_CAFE, 4'hF);
            xfer(d, 1'b1, 32'h04, 32'h0BAD_CAFE, 4'hF, 1'b0, o, pre, post, early);
            e = sb.pop_front();
            tests_run++;
            if (o !== e) begin
                tests_failed++;
                $display("FAIL b2b_write[%0d]: got %h expected %h", d, o, e);
            end
            push_exp(d, 1'b0, 32'h04, 32'd0, 4'h0);
            xfer(d, 1'b0, 32'h04, 32'd0, 4'h0, 1'b1, o, pre, post, early);
            e = sb.pop_front();
            tests_run++;
            if (o !== e) begin
                tests_failed++;
                $display("FAIL b2b_read[%0d]: got %h expected %h", d, o, e);
            end
            tests_run++;
            if ({pre, post} !== 2'b00) begin
                tests_failed++;
                $display("FAIL b2b_single_ready[%0d]: got pre=%b post=%b expected 0 0", d, pre, post);
            end
        end
    endtask

    task automatic test_done_ignore();
        int stray;
        stray = 0;
        tdr1 = 32'h7777_0001;
        @(negedge clk);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h08; pwdata = 32'h1; pstrb = 4'hF;
        @(negedge clk);
        tests_run++;
        if ({pready_w[0], wr_en_w[0]} !== 2'b11) begin
            tests_failed++;
            $display("FAIL done_ignore_first: got rdy=%b wr=%b expected 1 1", pready_w[0], wr_en_w[0]);
        end
        pwrite = 1'b0;
        @(negedge clk);
        stray += int'(pready_w[0]) + int'(rd_en_w[0]) + int'(wr_en_w[0]);
        psel = 1'b0;
        @(negedge clk);
        stray += int'(pready_w[0]) + int'(rd_en_w[0]) + int'(wr_en_w[0]);
        tests_run++;
        if (stray !== 0) begin
            tests_failed++;
            $display("FAIL done_ignore_setup: got %0d stray strobes expected 0", stray);
        end
    endtask

    initial begin
        tests_run = 0; tests_failed = 0;
        rst = 1'b1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0; pstrb = '0;
        tcr = 32'h0000_0001; tdr0 = 32'h1000_0002; tdr1 = 32'h2000_0003; tcmp0 = 32'h3000_0004;
        tcmp1 = 32'h4000_0005; tier = 32'h5000_0006; tisr = 32'h6000_0007; thcsr = 32'h7000_0008;
        test_reset();
        test_write_ws0();
        test_read_ws2();
        test_partial_write();
        test_read_decode();
        test_invalid();
        test_abort_reset();
        test_back_to_back();
        test_done_ignore();
        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded 200000 time units");
        $fatal(1);
    end

endmodule

// File: doc/timer_apb_slave.md
TIMER_APB_SLAVE -- requirements
Module: timer_apb_slave

Interface
REQ-001 SHALL have parameter WAIT_STATES, default 0, meaning the number of cycles pready is held low in the access phase (legal range 0-15).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 SHALL have APB inputs: psel (1), penable (1), pwrite (1), paddr (32), pwdata (32), pstrb (4).
REQ-005 SHALL have APB outputs: pready (1), prdata (32), pslverr (1).
REQ-006 SHALL have register-side outputs: wr_en (1), rd_en (1), addr (32), wdata (32).
REQ-007 SHALL have register readback inputs, each 32 bits: tcr, tdr0, tdr1, tcmp0, tcmp1, tier, tisr, thcsr.

Function
REQ-008 SHALL decode valid addresses as follows: 0x00 tcr, 0x04 tdr0, 0x08 tdr1, 0x0C tcmp0, 0x10 tcmp1, 0x14 tier, 0x18 tisr, 0x1C thcsr.
REQ-009 SHALL treat any other paddr as invalid, including misaligned addresses (paddr[1:0] != 0) and any address above 0x1C.
REQ-010 SHALL implement the FSM states IDLE, WAIT and DONE.
REQ-011 IDLE behaviour: on psel=1 and penable=0 (setup phase), latch paddr, pwrite, pwdata and pstrb, then go to DONE if WAIT_STATES=0, otherwise go to WAIT with cnt=WAIT_STATES-1.
REQ-012 WAIT behaviour: if cnt=0, go to DONE; otherwise decrement cnt.
REQ-013 WAIT abort: if psel=0, go to IDLE with no wr_en or rd_en pulse.
REQ-014 DONE behaviour: always go to IDLE on the next edge.
REQ-015 pready SHALL be 1 only in DONE, so a transfer completes in access cycle WAIT_STATES+1.
REQ-016 addr SHALL equal the latched paddr from the setup-edge onward.
REQ-017 wr_en SHALL be 1 only in DONE, and only for a latched write to a valid address; exactly one cycle per transfer.
REQ-018 rd_en SHALL be 1 only in DONE, and only for a latched read to a valid address; exactly one cycle per transfer.
REQ-019 wdata SHALL be formed byte-wise from pwdata: for each lane, use pwdata where the latched pstrb bit is 1, otherwise use the current readback value of the addressed register.
REQ-020 pstrb=0000 on a write SHALL give wr_en=1 with wdata equal to the unchanged readback value.
REQ-021 prdata SHALL be registered on entry to DONE from the addressed readback input, and SHALL be 0 in every other state, for writes, and for invalid addresses.
REQ-022 A new setup phase arriving while in DONE SHALL be ignored; the next transfer is accepted only from IDLE.

Reset
REQ-023 While rst=1, all of the following SHALL hold: state=IDLE, cnt=0, pready=0, prdata=0, pslverr=0, wr_en=0, rd_en=0, addr=0, wdata=0.
REQ-024 Asserting rst mid-transfer SHALL abort the transfer with no write pulse; the first setup phase after release SHALL be accepted normally.

Configuration
REQ-025 SHALL have macro APB_TIMER_PSLVERR_EN controlling error signalling.
REQ-026 With APB_TIMER_PSLVERR_EN defined: pslverr=1 in DONE for an invalid address, and no wr_en or rd_en pulse is issued.
REQ-027 Without APB_TIMER_PSLVERR_EN: pslverr is tied to 0, invalid writes are dropped silently, and invalid reads return 0.

Verification
REQ-028 WAIT_STATES=0: write 0x0000_1234 to 0x0C with pstrb=1111. Required: pready=1 in the first access cycle, wr_en=1 for 1 cycle, addr=0x0C, wdata=0x0000_1234.
REQ-029 WAIT_STATES=2: read 0x10 with tcmp1=0xFFFF_FFFF. Required: pready low for 2 access cycles, then prdata=0xFFFF_FFFF with rd_en=1 in access cycle 3.
REQ-030 Partial write: tcmp0=0xFFFF_FFFF, write pwdata=0x0000_00AB with pstrb=0001 to 0x0C. Required: wdata=0xFFFF_FFAB.
REQ-031 Invalid address: write to 0x20, then read 0x0D. Required, with APB_TIMER_PSLVERR_EN: pslverr=1 and wr_en=rd_en=0. Required, without it: pslverr=0 and prdata=0.
REQ-032 Abort: WAIT_STATES=3, rst=1 in the second access cycle of a write. Required: outputs at reset values, no wr_en; the next read of 0x00 completes normally.
REQ-033 Back-to-back transfers: write 0x04 then immediately read 0x04. Required: each transfer gets exactly one pready pulse, and the read returns the tdr0 input value.
